// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD bus engines: timing
// conversion helpers, register-select encodings and read-engine states.
package lcd_pkg;

  // RS line encodings: instruction/status register vs. data RAM
  localparam logic RS_INSTR = 1'b0;
  localparam logic RS_DATA  = 1'b1;

  // Busy flag position in the status byte; address counter occupies [6:0]
  localparam int BF_BIT = 7;

  typedef struct packed {
    logic       bf;
    logic [6:0] ac;
  } lcd_status_t;

  // Read engine states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_GNT = 3'd1,
    ST_SETUP    = 3'd2,
    ST_EHIGH    = 3'd3,
    ST_ELOW     = 3'd4,
    ST_DONE     = 3'd5
  } rd_state_t;

  // Nanoseconds to clock cycles, rounded up, never less than one cycle
  function automatic int ns2cyc(input int ns, input int clk_khz);
    longint p;
    longint c;
    p = longint'(ns) * longint'(clk_khz);
    c = (p + 64'sd999999) / 64'sd1000000;
    if (c < 1) c = 1;
    return int'(c);
  endfunction

  // Microseconds to clock cycles, rounded up, never less than one cycle
  function automatic int us2cyc(input int us, input int clk_khz);
    longint p;
    longint c;
    p = longint'(us) * longint'(clk_khz);
    c = (p + 64'sd999) / 64'sd1000;
    if (c < 1) c = 1;
    return int'(c);
  endfunction

endpackage

// File: rtl/lcd_cycle_timer.sv
// Loadable down-counter used to time each bus phase. Loading N makes
// o_done assert during the N-th cycle after the load edge, i.e. on the
// last cycle of an N-cycle phase.
module lcd_cycle_timer #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_count;

  // Load on phase entry, otherwise count down and rest at zero
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_done = (r_count == W'(1));

endmodule

// File: rtl/lcd_read_controller.sv
// Read-side engine for the HD44780-style LCD bus. Runs RW=1 bus cycles
// for status reads (optionally polling until BF=0) and data reads, and
// returns the last byte read with a one-cycle response pulse.
//
// Request/response handshake: a request is taken on a cycle where
// req_valid && req_ready (req_ready is high only in IDLE); there is no
// backpressure on the response, rsp_valid is a single-cycle pulse and
// rsp_data/rsp_timeout hold their value until the next pulse.
module lcd_read_controller
  import lcd_pkg::*;
#(
  parameter int CLK_KHZ         = 20000,
  parameter int ADDR_SETUP_NS   = 100,
  parameter int E_HIGH_NS       = 500,
  parameter int E_LOW_NS        = 500,
  parameter int POLL_TIMEOUT_US = 10000
) (
  input  logic       mclk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic       req_poll,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_timeout,
  output logic       bus_req,
  input  logic       bus_gnt,
  output logic       RS,
  output logic       RW,
  output logic       E,
  input  logic [7:0] DB_in,
  output logic [2:0] dbg_state
);

  localparam int SETUP_C = ns2cyc(ADDR_SETUP_NS, CLK_KHZ);
  localparam int EH_C    = ns2cyc(E_HIGH_NS, CLK_KHZ);
  localparam int EL_C    = ns2cyc(E_LOW_NS, CLK_KHZ);
  localparam int TMO_C   = us2cyc(POLL_TIMEOUT_US, CLK_KHZ);
  localparam int TMO_W   = $clog2(TMO_C) + 1;
  localparam int MAX_C   = (SETUP_C > EH_C) ? ((SETUP_C > EL_C) ? SETUP_C : EL_C)
                                            : ((EH_C > EL_C) ? EH_C : EL_C);
  localparam int CYC_W   = $clog2(MAX_C + 1);

  rd_state_t        r_state;
  rd_state_t        w_next;
  logic             r_rs;
  logic             r_poll;
  logic [7:0]       r_data;
  logic [TMO_W-1:0] r_tmo;
  logic [7:0]       r_rsp_data;
  logic             r_rsp_timeout;

  logic             w_accept;
  logic             w_in_cycle;
  logic             w_tmo_left;
  logic             w_bf;
  logic             w_tmr_load;
  logic [CYC_W-1:0] w_tmr_val;
  logic             w_tmr_done;

  assign w_accept   = (r_state == ST_IDLE) && req_valid;
  assign w_in_cycle = (r_state == ST_SETUP) || (r_state == ST_EHIGH) || (r_state == ST_ELOW);
  assign w_tmo_left = (r_tmo != '0);
  assign w_bf       = r_data[BF_BIT];

  lcd_cycle_timer #(
    .W(CYC_W)
  ) u_phase_timer (
    .i_clk      (mclk),
    .i_rst_n    (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_done     (w_tmr_done)
  );

  // State register
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; a lost grant during a bus cycle aborts straight to DONE
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) w_next = ST_WAIT_GNT;
      end
      ST_WAIT_GNT: begin
        if (bus_gnt) w_next = ST_SETUP;
      end
      ST_SETUP: begin
        if (!bus_gnt)       w_next = ST_DONE;
        else if (w_tmr_done) w_next = ST_EHIGH;
      end
      ST_EHIGH: begin
        if (!bus_gnt)       w_next = ST_DONE;
        else if (w_tmr_done) w_next = ST_ELOW;
      end
      ST_ELOW: begin
        if (!bus_gnt) begin
          w_next = ST_DONE;
        end else if (w_tmr_done) begin
          // Keep the bus and read again while busy and time remains
          if (r_poll && w_bf && w_tmo_left) w_next = ST_SETUP;
          else                              w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Phase timer reload whenever a timed phase is entered
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    if (w_next != r_state) begin
      case (w_next)
        ST_SETUP: begin
          w_tmr_load = 1'b1;
          w_tmr_val  = CYC_W'(SETUP_C);
        end
        ST_EHIGH: begin
          w_tmr_load = 1'b1;
          w_tmr_val  = CYC_W'(EH_C);
        end
        ST_ELOW: begin
          w_tmr_load = 1'b1;
          w_tmr_val  = CYC_W'(EL_C);
        end
        default: begin
          w_tmr_load = 1'b0;
          w_tmr_val  = '0;
        end
      endcase
    end
  end

  // Request latch; polling only makes sense for status reads
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      r_rs   <= RS_INSTR;
      r_poll <= 1'b0;
    end else if (w_accept) begin
      r_rs   <= req_rs;
      r_poll <= req_poll && (req_rs == RS_INSTR);
    end
  end

  // Poll timeout: loaded at accept, counts every granted bus cycle, saturates at zero
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      r_tmo <= '0;
    end else if (w_accept) begin
      r_tmo <= TMO_W'(TMO_C);
    end else if (w_in_cycle && w_tmo_left) begin
      r_tmo <= r_tmo - TMO_W'(1);
    end
  end

  // Capture DB on the last E-high cycle, when the LCD output has long settled
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      r_data <= '0;
    end else if ((r_state == ST_EHIGH) && w_tmr_done && bus_gnt) begin
      r_data <= DB_in;
    end
  end

  // Response registers, updated only on entry to DONE so they hold between pulses
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      r_rsp_data    <= '0;
      r_rsp_timeout <= 1'b0;
    end else if ((w_next == ST_DONE) && (r_state != ST_DONE)) begin
      r_rsp_data    <= r_data;
      r_rsp_timeout <= !bus_gnt || (r_poll && w_bf);
    end
  end

  // Bus and handshake outputs decoded from state; E is gated by grant so a lost grant drops it at once
  always_comb begin
    req_ready = (r_state == ST_IDLE);
    bus_req   = (r_state == ST_WAIT_GNT) || w_in_cycle;
    RW        = w_in_cycle;
    RS        = w_in_cycle && (r_rs == RS_DATA);
    E         = (r_state == ST_EHIGH) && bus_gnt;
    rsp_valid = (r_state == ST_DONE);
  end

  assign rsp_data    = r_rsp_data;
  assign rsp_timeout = r_rsp_timeout;
  assign dbg_state   = r_state;

endmodule
